// File: rtl/tagged_merger_if.sv
// Stream interfaces for tagged_merger: untagged source streams (data_i) and the merged, tagged stream (tagged_i).
// Handshake: a beat moves on a rising edge where valid && ready; the sender holds valid and all fields until then.
interface data_i #(
  parameter type data_t = logic [15:0],
  parameter int  KEEP_W = 4
);
  data_t             data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

interface tagged_i #(
  parameter type data_t    = logic [15:0],
  parameter int  KEEP_W    = 4,
  parameter int  TAG_WIDTH = 2
);
  data_t                data;
  logic [TAG_WIDTH-1:0] tag;
  logic [KEEP_W-1:0]    keep;
  logic                 last;
  logic                 valid;
  logic                 ready;

  modport m (output data, tag, keep, last, valid, input ready);
  modport s (input data, tag, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_merger.sv
// N:1 round-robin stream merger that stamps each beat with its source index, optionally
// packet-atomic, with a 2-entry skid stage decoupling the output.
module tagged_merger #(
  parameter type data_t        = logic [15:0],
  parameter int  KEEP_W        = 4,
  parameter int  NUM_INPUTS    = 4,
  parameter int  TAG_WIDTH     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int  LAST_HANDLING = 1,
  parameter int  FILTER_KEEP   = 1
) (
  input  logic clk,
  input  logic rst,
  data_i.s     in [NUM_INPUTS],
  tagged_i.m   out,
  output logic dbg_state
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  typedef logic [TAG_WIDTH-1:0] idx_t;
  typedef struct packed {
    data_t             data;
    idx_t              tag;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  logic [NUM_INPUTS-1:0] in_valid, in_last, in_ready;
  data_t                 in_data [NUM_INPUTS];
  logic [KEEP_W-1:0]     in_keep [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign in_valid[i] = in[i].valid;
    assign in_last[i]  = in[i].last;
    assign in_data[i]  = in[i].data;
    assign in_keep[i]  = in[i].keep;
    assign in[i].ready = in_ready[i];
  end

  state_t     state_q, state_d;
  idx_t       rr_q, rr_d, lock_q, lock_d;
  idx_t       win_idx, gnt_idx, cand;
  logic       win_found, acc, drop, push, pop;
  beat_t      beat;
  beat_t      skid_q [2];
  logic       wr_q, rd_q, space_q;
  logic [1:0] cnt_q, cnt_d;

  function automatic idx_t next_idx(input idx_t g);
    return (g == idx_t'(NUM_INPUTS - 1)) ? '0 : g + idx_t'(1);
  endfunction

  // Arbiter: the only place an input valid reaches any ready.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = idx_t'((int'(rr_q) + k) % NUM_INPUTS);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_idx  = (state_q == LOCKED) ? lock_q : win_idx;
    acc      = space_q && ((state_q == LOCKED) ? in_valid[lock_q] : win_found);
    if (state_q == LOCKED) in_ready[lock_q] = space_q;
    else                   in_ready[win_idx] = space_q && win_found;
    beat      = '0;
    beat.data = in_data[gnt_idx];
    beat.tag  = gnt_idx;
    beat.keep = in_keep[gnt_idx];
    beat.last = in_last[gnt_idx];
    // Empty mid-packet beats vanish; an empty last beat still carries the boundary.
    drop = (FILTER_KEEP != 0) && acc && (beat.keep == '0) && !beat.last;
    push = acc && !drop;
    pop  = out.valid && out.ready;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    if (acc) begin
      if (state_q == IDLE) begin
        if ((LAST_HANDLING != 0) && !beat.last) begin
          state_d = LOCKED;
          lock_d  = gnt_idx;
        end else begin
          rr_d = next_idx(gnt_idx);
        end
      end else if (beat.last) begin
        state_d = IDLE;
        rr_d    = next_idx(gnt_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  // Space is registered, so a pop from a full skid only reopens the inputs a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      space_q   <= 1'b0;
    end else begin
      if (push) begin
        skid_q[wr_q] <= beat;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q   <= cnt_d;
      space_q <= (cnt_d != 2'd2);
    end
  end

  assign out.valid = (cnt_q != 2'd0);
  assign out.data  = skid_q[rd_q].data;
  assign out.tag   = skid_q[rd_q].tag;
  assign out.keep  = skid_q[rd_q].keep;
  assign out.last  = skid_q[rd_q].last;
  assign dbg_state = (state_q == LOCKED);

endmodule

// File: tb/tb_tagged_merger.sv
// Directed bench for tagged_merger: three instances (default, FILTER_KEEP=0, LAST_HANDLING=0)
// fed from per-source beat queues, outputs collected and compared against hand-computed beats.
module tb_tagged_merger;
  typedef logic [15:0] data_t;
  typedef struct packed {
    logic [1:0] tag;
    data_t      data;
    logic [3:0] keep;
    logic       last;
  } beat_t;
  localparam int ND = 3;
  localparam int NS = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv    [ND][NS];
  data_t      idata [ND][NS];
  logic [3:0] ikeep [ND][NS];
  logic       ilast [ND][NS];
  logic       rdy   [ND][NS];
  logic       ordy  [ND];
  logic       ov    [ND];
  logic [1:0] otag  [ND];
  data_t      odata [ND];
  logic [3:0] okeep [ND];
  logic       olast [ND];
  logic       dbg   [ND];

  for (genvar d = 0; d < ND; d++) begin : g_dut
    data_i   #(.data_t(data_t), .KEEP_W(4))                in_if [NS] ();
    tagged_i #(.data_t(data_t), .KEEP_W(4), .TAG_WIDTH(2)) out_if ();
    for (genvar s = 0; s < NS; s++) begin : g_src
      assign in_if[s].valid = iv[d][s];
      assign in_if[s].data  = idata[d][s];
      assign in_if[s].keep  = ikeep[d][s];
      assign in_if[s].last  = ilast[d][s];
      assign rdy[d][s]      = in_if[s].ready;
    end
    assign out_if.ready = ordy[d];
    assign ov[d]    = out_if.valid;
    assign otag[d]  = out_if.tag;
    assign odata[d] = out_if.data;
    assign okeep[d] = out_if.keep;
    assign olast[d] = out_if.last;
    tagged_merger #(
      .data_t(data_t), .KEEP_W(4), .NUM_INPUTS(NS), .TAG_WIDTH(2),
      .LAST_HANDLING((d == 2) ? 0 : 1), .FILTER_KEEP((d == 1) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .in(in_if), .out(out_if), .dbg_state(dbg[d])
    );
  end

  // scoreboard state
  beat_t src_q [ND][NS][$];
  beat_t obs_q [ND][$];
  int    obs_cyc [ND][$];
  logic  pend [ND][NS];
  int    acc_cnt [ND];
  int    first_acc [ND];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic beat_t get_obs(input int d, input int k);
    if (k < obs_q[d].size()) return obs_q[d][k];
    return '1;
  endfunction

  function automatic int get_cyc(input int d, input int k);
    if (k < obs_cyc[d].size()) return obs_cyc[d][k];
    return -1000;
  endfunction

  task automatic check_beat(input string name, input int d, input int k, input logic [1:0] tag,
                            input data_t data, input logic [3:0] keep, input logic last);
    beat_t e;
    e = '{tag: tag, data: data, keep: keep, last: last};
    check(name, 32'(get_obs(d, k)), 32'(e));
  endtask

  // driver tasks
  task automatic send(input int d, input int s, input data_t data, input logic [3:0] keep, input logic last);
    src_q[d][s].push_back('{tag: 2'd0, data: data, keep: keep, last: last});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic assert_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      for (int s = 0; s < NS; s++) begin
        src_q[d][s].delete();
        pend[d][s] = 1'b0;
      end
      obs_q[d].delete();
      obs_cyc[d].delete();
      acc_cnt[d]   = 0;
      first_acc[d] = -1;
      ordy[d]      = 1'b0;
    end
  endtask

  task automatic release_rst();
    step(2);
    rst = 1'b0;
  endtask

  // source presenters and output monitor
  initial begin
    beat_t hd;
    for (int d = 0; d < ND; d++) begin
      ordy[d] = 1'b0;
      acc_cnt[d] = 0;
      first_acc[d] = -1;
      for (int s = 0; s < NS; s++) pend[d][s] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        for (int s = 0; s < NS; s++) begin
          if (pend[d][s] && src_q[d][s].size() > 0) void'(src_q[d][s].pop_front());
          pend[d][s] = 1'b0;
          if (src_q[d][s].size() > 0) begin
            hd = src_q[d][s][0];
            iv[d][s] = 1'b1; idata[d][s] = hd.data; ikeep[d][s] = hd.keep; ilast[d][s] = hd.last;
          end else begin
            iv[d][s] = 1'b0; idata[d][s] = '0; ikeep[d][s] = '0; ilast[d][s] = 1'b0;
          end
        end
      end
      #3;
      for (int d = 0; d < ND; d++) begin
        for (int s = 0; s < NS; s++) begin
          if (iv[d][s] && rdy[d][s] && !rst) begin
            pend[d][s] = 1'b1;
            acc_cnt[d]++;
            if (first_acc[d] < 0) first_acc[d] = cyc;
          end
        end
        if (ov[d] && ordy[d] && !rst) begin
          obs_q[d].push_back('{tag: otag[d], data: odata[d], keep: okeep[d], last: olast[d]});
          obs_cyc[d].push_back(cyc);
        end
      end
    end
  end

  initial begin
    // T1: reset mid-packet with a beat waiting on out
    assert_rst();
    release_rst();
    ordy[0] = 1'b1;
    send(0, 0, 16'h0001, 4'hF, 1'b1);
    step(4);
    ordy[0] = 1'b0;
    send(0, 1, 16'h0101, 4'hF, 1'b0);
    send(0, 1, 16'h0102, 4'hF, 1'b0);
    send(0, 1, 16'h0103, 4'hF, 1'b1);
    step(5);
    check("t1_pre_valid", 32'(ov[0]), 32'd1);
    check("t1_pre_locked", 32'(dbg[0]), 32'd1);
    assert_rst();
    #1;
    check("t1_rst_valid", 32'(ov[0]), 32'd0);
    check("t1_rst_ready", 32'({rdy[0][3], rdy[0][2], rdy[0][1], rdy[0][0]}), 32'd0);
    check("t1_rst_state", 32'(dbg[0]), 32'd0);
    check("t1_rst_fields", 32'({otag[0], odata[0], okeep[0], olast[0]}), 32'd0);
    release_rst();
    send(0, 2, 16'h0201, 4'hF, 1'b1);
    send(0, 0, 16'h0002, 4'hF, 1'b1);
    ordy[0] = 1'b1;
    step(6);
    check("t1_count", 32'(obs_q[0].size()), 32'd2);
    check_beat("t1_beat0", 0, 0, 2'd0, 16'h0002, 4'hF, 1'b1);
    check_beat("t1_beat1", 0, 1, 2'd2, 16'h0201, 4'hF, 1'b1);

    // T2: round-robin over four always-valid sources
    assert_rst();
    release_rst();
    ordy[0] = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) send(0, s, 16'(s * 256 + r), 4'hF, 1'b1);
    step(14);
    check("t2_count", 32'(obs_q[0].size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check_beat($sformatf("t2_beat%0d", k), 0, k, 2'(k % 4), 16'((k % 4) * 256 + k / 4), 4'hF, 1'b1);
    check("t2_latency", 32'(get_cyc(0, 0) - first_acc[0]), 32'd1);
    check("t2_rate", 32'(get_cyc(0, 7) - get_cyc(0, 0)), 32'd7);

    // T3: packet atomicity, in1 waits behind in0's 3-beat packet
    assert_rst();
    release_rst();
    ordy[0] = 1'b1;
    send(0, 0, 16'h3000, 4'hF, 1'b0);
    send(0, 0, 16'h3001, 4'hF, 1'b0);
    send(0, 0, 16'h3002, 4'hF, 1'b1);
    step(1);
    send(0, 1, 16'h3100, 4'hF, 1'b1);
    step(1);
    check("t3_in1_wait_a", 32'(rdy[0][1]), 32'd0);
    check("t3_locked", 32'(dbg[0]), 32'd1);
    step(1);
    check("t3_in1_wait_b", 32'(rdy[0][1]), 32'd0);
    step(6);
    check("t3_count", 32'(obs_q[0].size()), 32'd4);
    check_beat("t3_beat0", 0, 0, 2'd0, 16'h3000, 4'hF, 1'b0);
    check_beat("t3_beat1", 0, 1, 2'd0, 16'h3001, 4'hF, 1'b0);
    check_beat("t3_beat2", 0, 2, 2'd0, 16'h3002, 4'hF, 1'b1);
    check_beat("t3_beat3", 0, 3, 2'd1, 16'h3100, 4'hF, 1'b1);

    // T4: five cycles of backpressure mid-stream
    assert_rst();
    release_rst();
    ordy[0] = 1'b1;
    for (int k = 0; k < 6; k++) send(0, 0, 16'(16'h0040 + k), 4'hF, 1'b1);
    step(3);
    ordy[0] = 1'b0;
    step(2);
    check("t4_buffered", 32'(acc_cnt[0] - obs_q[0].size()), 32'd2);
    check("t4_ready", 32'(rdy[0][0]), 32'd0);
    check("t4_head_a", 32'({ov[0], otag[0], odata[0]}), 32'({1'b1, 2'd0, 16'h0041}));
    step(3);
    check("t4_head_b", 32'({ov[0], otag[0], odata[0]}), 32'({1'b1, 2'd0, 16'h0041}));
    ordy[0] = 1'b1;
    step(10);
    check("t4_count", 32'(obs_q[0].size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check_beat($sformatf("t4_beat%0d", k), 0, k, 2'd0, 16'(16'h0040 + k), 4'hF, 1'b1);

    // T5: keep filter on, then off
    assert_rst();
    release_rst();
    for (int d = 0; d < 2; d++) begin
      ordy[d] = 1'b1;
      send(d, 2, 16'h5000, 4'h0, 1'b0);
      send(d, 2, 16'h5001, 4'hF, 1'b0);
      send(d, 2, 16'h5002, 4'h0, 1'b1);
    end
    step(8);
    check("t5_filt_count", 32'(obs_q[0].size()), 32'd2);
    check_beat("t5_filt_beat0", 0, 0, 2'd2, 16'h5001, 4'hF, 1'b0);
    check_beat("t5_filt_beat1", 0, 1, 2'd2, 16'h5002, 4'h0, 1'b1);
    check("t5_nofilt_count", 32'(obs_q[1].size()), 32'd3);
    check_beat("t5_nofilt_beat0", 1, 0, 2'd2, 16'h5000, 4'h0, 1'b0);
    check_beat("t5_nofilt_beat1", 1, 1, 2'd2, 16'h5001, 4'hF, 1'b0);
    check_beat("t5_nofilt_beat2", 1, 2, 2'd2, 16'h5002, 4'h0, 1'b1);

    // T6: per-beat arbitration interleaves packets
    assert_rst();
    release_rst();
    ordy[2] = 1'b1;
    send(2, 0, 16'h6000, 4'hF, 1'b0);
    send(2, 0, 16'h6001, 4'hF, 1'b1);
    send(2, 3, 16'h6300, 4'hF, 1'b0);
    send(2, 3, 16'h6301, 4'hF, 1'b1);
    step(8);
    check("t6_count", 32'(obs_q[2].size()), 32'd4);
    check_beat("t6_beat0", 2, 0, 2'd0, 16'h6000, 4'hF, 1'b0);
    check_beat("t6_beat1", 2, 1, 2'd3, 16'h6300, 4'hF, 1'b0);
    check_beat("t6_beat2", 2, 2, 2'd0, 16'h6001, 4'hF, 1'b1);
    check_beat("t6_beat3", 2, 3, 2'd3, 16'h6301, 4'hF, 1'b1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
